// File: rtl/fetch_unit.sv
// RV32I instruction fetch: single-outstanding word requests to imem, returned
// words queued with their PC in a small FIFO for decode; redirect flushes all.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WAIT_DROP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic [31:0]      r_fifo_pc   [DEPTH];
  logic [31:0]      r_fifo_word [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_last_pc;
  logic [31:0]      r_last_word;
  logic [CNT_W:0]   w_count_x;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_count_x   = {1'b0, r_count};
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_fifo_word[r_rd_ptr] : r_last_word;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : r_last_pc;

  // A new request may overlap the response cycle only if its word is sure to fit.
  always_comb begin
    imem_req = 1'b0;
    if (reset_n && !redirect) begin
      unique case (r_state)
        S_IDLE:      imem_req = (w_count_x < DEPTH_X);
        S_WAIT:      imem_req = imem_rvalid && ((w_count_x + 1'b1) < DEPTH_X);
        S_WAIT_DROP: imem_req = imem_rvalid;
        default:     imem_req = 1'b0;
      endcase
    end
  end

  assign w_grant = imem_req && imem_gnt;
  assign w_push  = (r_state == S_WAIT) && imem_rvalid && !redirect;
  assign w_pop   = instr_valid && instr_ready && !redirect;

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      if (r_state != S_IDLE && imem_rvalid) w_state_nxt = S_IDLE;
      else if (r_state == S_WAIT)           w_state_nxt = S_WAIT_DROP;
    end else if (w_grant) begin
      w_state_nxt = S_WAIT;
    end else if (r_state != S_IDLE && imem_rvalid) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_last_pc   <= '0;
      r_last_word <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_word[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (instr_valid) begin
        r_last_pc   <= r_fifo_pc[r_rd_ptr];
        r_last_word <= r_fifo_word[r_rd_ptr];
      end
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_req_pc   <= r_fetch_pc;
        end
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]   <= r_req_pc;
          r_fifo_word[r_wr_ptr] <= imem_rdata;
          r_wr_ptr              <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, with an
// instruction-stream reference model feeding a scoreboard drained by a monitor.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  ent_t        expq[$];
  int          pop_cnt = 0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_word = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented head against the scoreboard and drains it on accept.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      last_pc   = 32'h0;
      last_word = 32'h0;
    end else begin
      chk("instr_valid", 32'(instr_valid), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
        chk("instr_pc", instr_pc, expq[0].pc);
        chk("instr", instr, expq[0].word);
        last_pc   = expq[0].pc;
        last_word = expq[0].word;
      end else begin
        chk("hold_pc", instr_pc, last_pc);
        chk("hold_instr", instr, last_word);
      end
      if (!redirect && instr_ready && expq.size() != 0) begin
        void'(expq.pop_front());
        pop_cnt++;
      end
    end
  end

  // Reference model: tracks fetch address, the one outstanding request and
  // whether its word is still wanted; fills the scoreboard with kept words.
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_out_addr = 32'h0;
  bit          m_out = 1'b0;
  bit          m_drop = 1'b0;
  int          seen = 0;
  int          qpre;
  bit          exp_req;
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset_n) begin
      expq.delete();
      m_pc   = RESET_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
      seen   = pop_cnt;
    end else begin
      qpre = expq.size() + (pop_cnt - seen);
      seen = pop_cnt;
      if (redirect)          exp_req = 1'b0;
      else if (!m_out)       exp_req = (qpre < DEPTH);
      else if (!imem_rvalid) exp_req = 1'b0;
      else if (m_drop)       exp_req = 1'b1;
      else                   exp_req = (qpre + 1 < DEPTH);
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) chk("imem_addr", imem_addr, m_pc);
      if (redirect) begin
        expq.delete();
        if (m_out) begin
          if (imem_rvalid) m_out = 1'b0;
          else             m_drop = 1'b1;
        end
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_out && imem_rvalid) begin
          if (!m_drop) expq.push_back('{pc: m_out_addr, word: mem_word(m_out_addr)});
          m_out = 1'b0;
        end
        if (exp_req && imem_gnt) begin
          m_out      = 1'b1;
          m_drop     = 1'b0;
          m_out_addr = m_pc;
          m_pc       = m_pc + 32'd4;
        end
      end
    end
  end

  // Driver side: memory responder with programmable latency, grant log.
  int          lat = 1;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_wait = 0;
  logic [31:0] gq[$];
  bit          found;
  logic [31:0] held;

  task automatic step();
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_wait = lat - 1;
      gq.push_back(imem_addr);
    end
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend) begin
      if (mem_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 1'b0;
      end else begin
        mem_wait--;
      end
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    instr_ready = 1'b0;
    mem_pend    = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    gq.delete();
    #1;
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, RESET_PC);
  endtask

  initial begin
    #2;
    // Streaming with a one-cycle memory.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
    repeat (20) step();
    for (int i = 0; i < 3; i++)
      chk("stream_gnt_order", (gq.size() > i) ? gq[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Decode stalled: FIFO fills, requests stop, then drains in order.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b0; lat = 1;
    repeat (6) step();
    #1;
    chk("full_valid", 32'(instr_valid), 32'h1);
    chk("full_head_pc", instr_pc, 32'h0);
    chk("full_head_word", instr, mem_word(32'h0));
    chk("full_req_low", 32'(imem_req), 32'h0);
    chk("full_fetch_pc", imem_addr, 32'h8);
    instr_ready = 1'b1;
    repeat (10) step();

    // Slow memory, redirect while the fetch of 0x4 is in flight.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (gq.size() >= 2) found = 1'b1;
    end
    chk("slow_gnt4", (gq.size() >= 2) ? gq[1] : 32'hDEAD_BEEF, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h100;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (imem_rvalid) begin
        #1;
        found = 1'b1;
        chk("stale_cycle_req", 32'(imem_req), 32'h1);
        chk("stale_cycle_addr", imem_addr, 32'h100);
      end
    end
    chk("stale_rvalid_seen", 32'(found), 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      #1;
      if (instr_valid) begin
        found = 1'b1;
        chk("redir_first_pc", instr_pc, 32'h100);
      end
    end
    chk("redir_valid_seen", 32'(found), 32'h1);

    // Redirect coinciding with a response and a pop.
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b0; lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_rvalid && instr_valid) found = 1'b1;
    end
    chk("collide_setup", 32'(found), 32'h1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    #1;
    chk("collide_flushed", 32'(instr_valid), 32'h0);
    chk("collide_req", 32'(imem_req), 32'h1);
    chk("collide_addr", imem_addr, 32'h200);
    repeat (6) step();

    // Grant withheld, then redirect to the top of the address space.
    do_reset();
    imem_gnt = 1'b0; instr_ready = 1'b1; lat = 1;
    held = imem_addr;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("stall_req", 32'(imem_req), 32'h1);
      chk("stall_addr", imem_addr, held);
    end
    imem_gnt = 1'b1;
    step();
    #1;
    chk("stall_gnt_inc", imem_addr, held + 32'd4);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    gq.delete();
    for (int i = 0; i < 20 && gq.size() < 2; i++) step();
    chk("wrap_first", (gq.size() >= 1) ? gq[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_second", (gq.size() >= 2) ? gq[1] : 32'hDEAD_BEEF, 32'h0);

    // Asynchronous reset with a full FIFO, then a misaligned redirect.
    instr_ready = 1'b0;
    repeat (8) step();
    #1;
    chk("pre_reset_valid", 32'(instr_valid), 32'h1);
    do_reset();
    imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    #1;
    chk("misalign_addr", imem_addr, 32'h100);
    for (int i = 0; i < 10 && gq.size() < 1; i++) step();
    chk("misalign_gnt", (gq.size() >= 1) ? gq[0] : 32'hDEAD_BEEF, 32'h100);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      instr_ready = ($urandom_range(0, 9) < 7);
      lat         = int'($urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
